// File: rtl/dp_seq_pkg.sv
// Shared encodings for the sequenced register-file / ALU / memory datapath.
// Command kinds, ALU opcodes, FSM state codes and the shift-amount width helper.
package dp_seq_pkg;

  localparam logic [1:0] KIND_ALU_REG = 2'b00;
  localparam logic [1:0] KIND_LOAD    = 2'b01;
  localparam logic [1:0] KIND_STORE   = 2'b10;
  localparam logic [1:0] KIND_ALU_MEM = 2'b11;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;

  // Number of B bits that form the SLL shift amount.
  function automatic int shamt_w(input int data_w);
    return (data_w <= 1) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/dp_seq_alu.sv
// Combinational ALU: logic ops, modulo add/sub with signed overflow, signed SLT, SLL.
module dp_seq_alu
  import dp_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              of,
  output logic              zf
);

  localparam int SHW = shamt_w(DATA_W);

  logic [DATA_W-1:0] sum_s;
  logic [DATA_W-1:0] diff_s;
  logic [SHW-1:0]    shamt_s;

  // Result select; overflow only meaningful for ADD/SUB.
  always_comb begin
    sum_s   = a + b;
    diff_s  = a - b;
    shamt_s = b[SHW-1:0];
    y       = {DATA_W{1'b0}};
    of      = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      OP_ADD: begin
        y  = sum_s;
        of = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        y  = diff_s;
        of = (a[DATA_W-1] != b[DATA_W-1]) && (diff_s[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: y = a << shamt_s;
      default: y = {DATA_W{1'b0}};
    endcase
    zf = (y == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/dp_seq_core.sv
// Command-driven multicycle datapath: READ -> EXEC/MEM -> WB with a one-cycle done pulse.
// Register file and data memory are kept inline; register 0 is never written.
module dp_seq_core
  import dp_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 6
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  input  logic [REG_AW-1:0] cmd_rw,
  input  logic [MEM_AW-1:0] cmd_maddr,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_use_imm,
  output logic [DATA_W-1:0] Result,
  output logic [DATA_W-1:0] Data_Bus,
  output logic              OF,
  output logic              ZF,
  output logic              busy,
  output logic              done
);

  logic [2:0]        state_r;
  logic [1:0]        kind_r;
  logic [2:0]        op_r;
  logic [REG_AW-1:0] ra_r, rb_r, rw_r;
  logic [MEM_AW-1:0] maddr_r;
  logic [DATA_W-1:0] imm_r;
  logic              use_imm_r;
  logic [DATA_W-1:0] op_a_r, op_b_r, st_data_r;
  logic [DATA_W-1:0] result_r, data_bus_r;
  logic              of_r, zf_r, done_r;
  logic [DATA_W-1:0] regs_r [2**REG_AW];
  logic [DATA_W-1:0] mem_r  [2**MEM_AW];
  logic [DATA_W-1:0] alu_y_s;
  logic              alu_of_s, alu_zf_s;

  dp_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op (op_r),
    .a  (op_a_r),
    .b  (op_b_r),
    .y  (alu_y_s),
    .of (alu_of_s),
    .zf (alu_zf_s)
  );

  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign Result    = result_r;
  assign Data_Bus  = data_bus_r;
  assign OF        = of_r;
  assign ZF        = zf_r;
  assign done      = done_r;

  // Sequencer, operand/result registers and register file.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_r    <= ST_IDLE;
      kind_r     <= 2'b00;
      op_r       <= 3'b000;
      ra_r       <= {REG_AW{1'b0}};
      rb_r       <= {REG_AW{1'b0}};
      rw_r       <= {REG_AW{1'b0}};
      maddr_r    <= {MEM_AW{1'b0}};
      imm_r      <= {DATA_W{1'b0}};
      use_imm_r  <= 1'b0;
      op_a_r     <= {DATA_W{1'b0}};
      op_b_r     <= {DATA_W{1'b0}};
      st_data_r  <= {DATA_W{1'b0}};
      result_r   <= {DATA_W{1'b0}};
      data_bus_r <= {DATA_W{1'b0}};
      of_r       <= 1'b0;
      zf_r       <= 1'b0;
      done_r     <= 1'b0;
      for (int i = 0; i < 2**REG_AW; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            kind_r    <= cmd_kind;
            op_r      <= cmd_op;
            ra_r      <= cmd_ra;
            rb_r      <= cmd_rb;
            rw_r      <= cmd_rw;
            maddr_r   <= cmd_maddr;
            imm_r     <= cmd_imm;
            use_imm_r <= cmd_use_imm;
            state_r   <= ST_READ;
          end
        end
        ST_READ: begin
          op_a_r    <= regs_r[ra_r];
          op_b_r    <= use_imm_r ? imm_r : regs_r[rb_r];
          st_data_r <= regs_r[rb_r];
          state_r   <= (kind_r == KIND_ALU_REG || kind_r == KIND_ALU_MEM) ? ST_EXEC : ST_MEM;
        end
        ST_EXEC: begin
          result_r <= alu_y_s;
          of_r     <= alu_of_s;
          zf_r     <= alu_zf_s;
          state_r  <= (kind_r == KIND_ALU_MEM) ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          if (kind_r == KIND_LOAD) begin
            data_bus_r <= mem_r[maddr_r];
            result_r   <= mem_r[maddr_r];
            state_r    <= ST_WB;
          end else begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end
        end
        ST_WB: begin
          // Register 0 stays hard-wired to zero.
          if (rw_r != {REG_AW{1'b0}}) regs_r[rw_r] <= result_r;
          state_r <= ST_IDLE;
          done_r  <= 1'b1;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Data memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_MEM && kind_r != KIND_LOAD) begin
      mem_r[maddr_r] <= (kind_r == KIND_STORE) ? st_data_r : result_r;
    end
  end

endmodule

// File: tb/tb_dp_seq_core.sv
// Randomised self-checking bench for dp_seq_core against an architectural model
// (register/memory arrays updated once per command, ALU from plain arithmetic).
module tb_dp_seq_core;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_kind = 2'b00;
  logic [2:0]  cmd_op = 3'b000;
  logic [4:0]  cmd_ra = 5'd0, cmd_rb = 5'd0, cmd_rw = 5'd0;
  logic [5:0]  cmd_maddr = 6'd0;
  logic [31:0] cmd_imm = 32'd0;
  logic        cmd_use_imm = 1'b0;
  logic [31:0] Result, Data_Bus;
  logic        OF, ZF, busy, done;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];
  bit          m_ok  [64];
  logic [31:0] exp_result = 32'd0, exp_bus = 32'd0;
  logic        exp_of = 1'b0, exp_zf = 1'b0;

  dp_seq_core #(.DATA_W(32), .REG_AW(5), .MEM_AW(6)) dut (
    .clk(clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_rw(cmd_rw), .cmd_maddr(cmd_maddr), .cmd_imm(cmd_imm),
    .cmd_use_imm(cmd_use_imm), .Result(Result), .Data_Bus(Data_Bus),
    .OF(OF), .ZF(ZF), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] y, output logic of);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    of = 1'b0;
    case (op)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: y = a ^ b;
      3'd3: y = ~(a | b);
      3'd4: begin s = sa + sb; y = s[31:0]; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd5: begin s = sa - sb; y = s[31:0]; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd6: y = (sa < sb) ? 32'd1 : 32'd0;
      default: y = a << b[4:0];
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    exp_result = 32'd0; exp_bus = 32'd0; exp_of = 1'b0; exp_zf = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] k, input logic [2:0] op, input logic [4:0] ra,
                             input logic [4:0] rb, input logic [4:0] rw, input logic [5:0] ma,
                             input logic [31:0] imm, input logic ui);
    logic [31:0] a, b, y;
    logic of;
    a = m_reg[ra];
    b = ui ? imm : m_reg[rb];
    case (k)
      2'd0: begin
        ref_alu(op, a, b, y, of);
        exp_result = y; exp_of = of; exp_zf = (y == 32'd0);
        if (rw != 5'd0) m_reg[rw] = y;
      end
      2'd1: begin
        exp_bus = m_mem[ma]; exp_result = m_mem[ma];
        if (rw != 5'd0) m_reg[rw] = m_mem[ma];
      end
      2'd2: begin m_mem[ma] = m_reg[rb]; m_ok[ma] = 1'b1; end
      default: begin
        ref_alu(op, a, b, y, of);
        exp_result = y; exp_of = of; exp_zf = (y == 32'd0);
        m_mem[ma] = y; m_ok[ma] = 1'b1;
      end
    endcase
  endtask

  task automatic drive_cmd(input logic [1:0] k, input logic [2:0] op, input logic [4:0] ra,
                           input logic [4:0] rb, input logic [4:0] rw, input logic [5:0] ma,
                           input logic [31:0] imm, input logic ui);
    cmd_kind = k; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rw = rw;
    cmd_maddr = ma; cmd_imm = imm; cmd_use_imm = ui;
  endtask

  task automatic run_cmd(input logic [1:0] k, input logic [2:0] op, input logic [4:0] ra,
                         input logic [4:0] rb, input logic [4:0] rw, input logic [5:0] ma,
                         input logic [31:0] imm, input logic ui);
    int first, pulses, exp_lat;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_idle: got %b want 1", cmd_ready); end
    drive_cmd(k, op, ra, rb, rw, ma, imm, ui);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    drive_cmd(2'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              6'($urandom), $urandom, 1'($urandom));
    model_apply(k, op, ra, rb, rw, ma, imm, ui);
    exp_lat = (k == 2'd2) ? 3 : 4;
    first = 0; pulses = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin pulses++; if (first == 0) first = c; end
    end
    vectors++;
    if (first != exp_lat) begin miscompares++; $display("FAIL done_latency kind=%0d: got %0d want %0d", k, first, exp_lat); end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL done_pulses: got %0d want 1", pulses); end
    vectors++;
    if (Result !== exp_result) begin miscompares++; $display("FAIL result kind=%0d op=%0d: got %h want %h", k, op, Result, exp_result); end
    vectors++;
    if (OF !== exp_of || ZF !== exp_zf) begin miscompares++; $display("FAIL flags: got OF=%b ZF=%b want OF=%b ZF=%b", OF, ZF, exp_of, exp_zf); end
    vectors++;
    if (Data_Bus !== exp_bus) begin miscompares++; $display("FAIL data_bus: got %h want %h", Data_Bus, exp_bus); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (Result !== 32'd0 || Data_Bus !== 32'd0 || OF !== 1'b0 || ZF !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got R=%h DB=%h OF=%b ZF=%b done=%b busy=%b want all 0", Result, Data_Bus, OF, ZF, done, busy);
    end
    Reset = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b want 1", cmd_ready); end
  endtask

  task automatic test_directed();
    run_cmd(2'd0, 3'd4, 5'd0, 5'd0, 5'd1, 6'd0, 32'd5, 1'b1);
    run_cmd(2'd0, 3'd4, 5'd1, 5'd0, 5'd2, 6'd0, 32'h7FFF_FFFF, 1'b1);
    vectors++;
    if (Result !== 32'h8000_0004 || OF !== 1'b1 || ZF !== 1'b0) begin
      miscompares++; $display("FAIL add_overflow: got %h OF=%b ZF=%b want 80000004 1 0", Result, OF, ZF);
    end
    run_cmd(2'd0, 3'd5, 5'd1, 5'd0, 5'd0, 6'd0, 32'd5, 1'b1);
    vectors++;
    if (Result !== 32'd0 || ZF !== 1'b1 || OF !== 1'b0) begin
      miscompares++; $display("FAIL sub_zero: got %h ZF=%b OF=%b want 0 1 0", Result, ZF, OF);
    end
    run_cmd(2'd0, 3'd1, 5'd0, 5'd0, 5'd3, 6'd0, 32'd0, 1'b1);
    vectors++;
    if (Result !== 32'd0) begin miscompares++; $display("FAIL r0_unchanged: got %h want 0", Result); end
    run_cmd(2'd2, 3'd0, 5'd0, 5'd2, 5'd0, 6'd63, 32'd0, 1'b0);
    run_cmd(2'd1, 3'd0, 5'd0, 5'd0, 5'd4, 6'd63, 32'd0, 1'b0);
    vectors++;
    if (Data_Bus !== 32'h8000_0004 || Result !== 32'h8000_0004) begin
      miscompares++; $display("FAIL load_back: got DB=%h R=%h want 80000004", Data_Bus, Result);
    end
    run_cmd(2'd0, 3'd1, 5'd4, 5'd0, 5'd5, 6'd0, 32'd1, 1'b1);
    vectors++;
    if (Result !== 32'h8000_0005) begin miscompares++; $display("FAIL or_loaded: got %h want 80000005", Result); end
  endtask

  task automatic test_back_to_back();
    int pulses, d1, d2;
    logic [31:0] imm1;
    imm1 = $urandom;
    @(negedge clk);
    drive_cmd(2'd0, 3'd4, 5'd1, 5'd0, 5'd6, 6'd0, imm1, 1'b1);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    drive_cmd(2'd0, 3'd2, 5'd6, 5'd1, 5'd7, 6'd0, 32'd0, 1'b0);
    model_apply(2'd0, 3'd4, 5'd1, 5'd0, 5'd6, 6'd0, imm1, 1'b1);
    model_apply(2'd0, 3'd2, 5'd6, 5'd1, 5'd7, 6'd0, 32'd0, 1'b0);
    pulses = 0; d1 = 0; d2 = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        vectors++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
          miscompares++; $display("FAIL b2b_ready_busy c=%0d: got ready=%b busy=%b want 0 1", c, cmd_ready, busy);
        end
      end
      if (c == 5) cmd_valid = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
      end
    end
    vectors++;
    if (pulses != 2 || d1 != 4 || d2 != 8) begin
      miscompares++; $display("FAIL b2b_done: got %0d pulses at %0d,%0d want 2 at 4,8", pulses, d1, d2);
    end
    vectors++;
    if (Result !== exp_result || ZF !== exp_zf) begin
      miscompares++; $display("FAIL b2b_result: got %h ZF=%b want %h ZF=%b", Result, ZF, exp_result, exp_zf);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    drive_cmd(2'd0, 3'd4, 5'd0, 5'd0, 5'd5, 6'd0, 32'd9, 1'b1);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (Result !== 32'd0 || OF !== 1'b0 || ZF !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_state: got R=%h OF=%b ZF=%b done=%b busy=%b want 0", Result, OF, ZF, done, busy);
    end
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    Reset = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    run_cmd(2'd0, 3'd4, 5'd5, 5'd0, 5'd3, 6'd0, 32'd0, 1'b1);
    vectors++;
    if (Result !== 32'd0 || ZF !== 1'b1) begin miscompares++; $display("FAIL abort_r5: got %h ZF=%b want 0 1", Result, ZF); end
  endtask

  task automatic test_random(input int n);
    logic [1:0]  k;
    logic [5:0]  ma;
    logic [31:0] imm;
    int sel;
    for (int i = 0; i < n; i++) begin
      k  = 2'($urandom_range(0, 3));
      ma = 6'($urandom);
      if (k == 2'd1) begin
        // Load only from words the model has written.
        if (!m_ok[ma]) begin
          k = 2'd2;
          for (int j = 0; j < 64; j++) if (m_ok[j]) begin ma = 6'(j); k = 2'd1; end
        end
      end
      sel = $urandom_range(0, 5);
      case (sel)
        0: imm = 32'h7FFF_FFFF;
        1: imm = 32'h8000_0000;
        2: imm = 32'hFFFF_FFFF;
        default: imm = $urandom;
      endcase
      run_cmd(k, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), ma, imm, 1'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin m_mem[i] = 32'd0; m_ok[i] = 1'b0; end
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_random(60);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
